crc_data_buffer: RTL and testbench



---
 rtl/crc_data_buffer.sv | 182 ++++++++++++++++++
 tb/tb_crc_data_buffer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_data_buffer.sv
// Two-entry CRC_DR write buffer: applies input bit reversal, serialises each stored
// transfer LSB-byte-first to the CRC engine, and sequences chain resets.
module crc_data_buffer #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] bus_wr,
  input  logic [1:0]  bus_size,
  input  logic [1:0]  rev_in_type,
  input  logic        buffer_write_en,
  input  logic        reset_chain,
  input  logic        byte_ready,
  input  logic        engine_busy,
  input  logic        crc_rst_ack,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  output logic        byte_last,
  output logic        buffer_full,
  output logic        read_wait,
  output logic        reset_pending,
  output logic        crc_rst_req
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned NB_W   = 3;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned CNT_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_REQ   = 2'd2
  } rst_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [NB_W-1:0]   nbytes;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  rst_state_e       state_q, state_d;

  entry_t            head;
  logic [DATA_W-1:0] head_shifted;
  logic [NB_W-1:0]   head_last_idx;
  logic              handshake;
  logic              pop;
  logic              flush;
  logic              wr_accept;

  function automatic logic [7:0] rev8(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = x[7-i];
    return r;
  endfunction

  function automatic logic [15:0] rev16(input logic [15:0] x);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = x[15-i];
    return r;
  endfunction

  function automatic logic [31:0] rev32(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = x[31-i];
    return r;
  endfunction

  // Reversal is limited to the valid width; wider modes collapse to the transfer width.
  function automatic logic [31:0] reverse_in(input logic [31:0] w, input logic [1:0] size,
                                             input logic [1:0] mode);
    logic [31:0] r;
    r = '0;
    case (size)
      2'd0: r[7:0] = (mode == 2'd0) ? w[7:0] : rev8(w[7:0]);
      2'd1: begin
        case (mode)
          2'd0:    r[15:0] = w[15:0];
          2'd1:    r[15:0] = {rev8(w[15:8]), rev8(w[7:0])};
          default: r[15:0] = rev16(w[15:0]);
        endcase
      end
      default: begin
        case (mode)
          2'd0:    r = w;
          2'd1:    r = {rev8(w[31:24]), rev8(w[23:16]), rev8(w[15:8]), rev8(w[7:0])};
          2'd2:    r = {rev16(w[31:16]), rev16(w[15:0])};
          default: r = rev32(w);
        endcase
      end
    endcase
    return r;
  endfunction

  function automatic logic [NB_W-1:0] size_to_nbytes(input logic [1:0] size);
    case (size)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Output decode from the state flops
  assign head          = mem_q[rd_ptr_q];
  assign head_shifted  = head.data >> {idx_q, 3'b000};
  assign head_last_idx = head.nbytes - 3'd1;
  assign reset_pending = (state_q != ST_IDLE);
  assign crc_rst_req   = (state_q == ST_REQ);
  assign byte_valid    = (count_q != '0) && !reset_pending;
  assign byte_last     = byte_valid && ({1'b0, idx_q} == head_last_idx);
  assign byte_out      = byte_valid ? head_shifted[7:0] : 8'h00;
  assign buffer_full   = (count_q == CNT_W'(2));
  assign read_wait     = (count_q != '0) || engine_busy || reset_pending;

  assign handshake = byte_valid && byte_ready;
  assign pop       = handshake && byte_last;
  assign flush     = (state_q == ST_IDLE) && reset_chain;
  assign wr_accept = buffer_write_en && !buffer_full && !reset_pending && !reset_chain;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    idx_d    = idx_q;
    state_d  = state_q;

    case (state_q)
      ST_IDLE:  if (reset_chain)  state_d = ST_FLUSH;
      ST_FLUSH: if (!engine_busy) state_d = ST_REQ;
      ST_REQ:   if (crc_rst_ack)  state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase

    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = '0;
      idx_d    = '0;
    end else begin
      if (handshake) begin
        if (pop) begin
          idx_d    = '0;
          rd_ptr_d = ~rd_ptr_q;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      if (wr_accept) begin
        mem_d[wr_ptr_q] = '{data:   reverse_in(bus_wr, bus_size, rev_in_type),
                            nbytes: size_to_nbytes(bus_size)};
        wr_ptr_d        = ~wr_ptr_q;
      end
      count_d = count_q + CNT_W'(wr_accept) - CNT_W'(pop);
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
      idx_q    <= '0;
      state_q  <= ST_IDLE;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      state_q  <= state_d;
    end
  end

endmodule

// File: tb/tb_crc_data_buffer.sv
// Bench for crc_data_buffer: directed scenarios plus a random phase, all checked
// every cycle against a transfer-queue reference model.
module tb_crc_data_buffer;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic [31:0] bus_wr = '0;
  logic [1:0]  bus_size = '0;
  logic [1:0]  rev_in_type = '0;
  logic        buffer_write_en = 1'b0;
  logic        reset_chain = 1'b0;
  logic        byte_ready = 1'b0;
  logic        engine_busy = 1'b0;
  logic        crc_rst_ack = 1'b0;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_last;
  logic        buffer_full;
  logic        read_wait;
  logic        reset_pending;
  logic        crc_rst_req;

  crc_data_buffer #(.DEPTH(2)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus_wr(bus_wr), .bus_size(bus_size),
    .rev_in_type(rev_in_type), .buffer_write_en(buffer_write_en),
    .reset_chain(reset_chain), .byte_ready(byte_ready), .engine_busy(engine_busy),
    .crc_rst_ack(crc_rst_ack), .byte_out(byte_out), .byte_valid(byte_valid),
    .byte_last(byte_last), .buffer_full(buffer_full), .read_wait(read_wait),
    .reset_pending(reset_pending), .crc_rst_req(crc_rst_req)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [31:0] d;
    int          n;
  } ent_t;

  ent_t mq[$];
  int   midx;
  int   mrs;        // 0 idle, 1 waiting for engine, 2 requesting
  int   vecs = 0;
  int   errs = 0;
  logic last_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int size_bytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  // Mirror each bit inside groups of g bits within the valid width
  function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [1:0] rv);
    int nb;
    int width;
    int g;
    logic [31:0] r;
    nb = size_bytes(sz);
    width = nb * 8;
    r = '0;
    case (rv)
      2'd0:    g = 1;
      2'd1:    g = 8;
      2'd2:    g = 16;
      default: g = 32;
    endcase
    if (g > width) g = width;
    for (int i = 0; i < width; i++) r[(i / g) * g + (g - 1 - i % g)] = w[i];
    return r;
  endfunction

  task automatic model_reset();
    mq.delete();
    midx = 0;
    mrs = 0;
  endtask

  // Check all outputs against the model, then advance model and clock by one cycle
  task automatic step();
    int   cnt;
    logic v;
    logic l;
    logic acc;
    logic [7:0] eb;
    ent_t e;
    #1;
    cnt = mq.size();
    v = (cnt != 0) && (mrs == 0);
    eb = 8'h00;
    l = 1'b0;
    acc = 1'b0;
    if (v) begin
      eb = 8'(mq[0].d >> (8 * midx));
      l = (midx == mq[0].n - 1);
    end
    chk("byte_valid", 32'(byte_valid), 32'(v));
    chk("byte_out", 32'(byte_out), 32'(eb));
    chk("byte_last", 32'(byte_last), 32'(l));
    chk("buffer_full", 32'(buffer_full), 32'(cnt == 2));
    chk("read_wait", 32'(read_wait), 32'((cnt != 0) || engine_busy || (mrs != 0)));
    chk("reset_pending", 32'(reset_pending), 32'(mrs != 0));
    chk("crc_rst_req", 32'(crc_rst_req), 32'(mrs == 2));
    if (mrs == 0 && reset_chain) begin
      mq.delete();
      midx = 0;
      mrs = 1;
    end else begin
      acc = buffer_write_en && (cnt < 2) && (mrs == 0);
      if (v && byte_ready) begin
        if (l) begin
          mq.delete(0);
          midx = 0;
        end else begin
          midx++;
        end
      end
      if (acc) begin
        e.d = ref_store(bus_wr, bus_size, rev_in_type);
        e.n = size_bytes(bus_size);
        mq.push_back(e);
      end
      if (mrs == 1 && !engine_busy) mrs = 2;
      else if (mrs == 2 && crc_rst_ack) mrs = 0;
    end
    last_acc = acc;
    @(posedge HCLK);
    @(negedge HCLK);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(byte_valid), 32'(0));
    chk({tag, "_out"}, 32'(byte_out), 32'(0));
    chk({tag, "_last"}, 32'(byte_last), 32'(0));
    chk({tag, "_full"}, 32'(buffer_full), 32'(0));
    chk({tag, "_rwait"}, 32'(read_wait), 32'(0));
    chk({tag, "_pend"}, 32'(reset_pending), 32'(0));
    chk({tag, "_req"}, 32'(crc_rst_req), 32'(0));
  endtask

  task automatic set_wr(input logic [31:0] d, input logic [1:0] sz, input logic [1:0] rv);
    bus_wr = d;
    bus_size = sz;
    rev_in_type = rv;
    buffer_write_en = 1'b1;
  endtask

  initial begin
    logic [7:0]  got[$];
    logic [31:0] words[3];
    logic [7:0]  wexp[4];
    int          c_at;
    logic        req_active;

    model_reset();
    last_acc = 1'b0;

    // Power-on reset
    repeat (2) @(negedge HCLK);
    #1;
    chk_all_zero("por");
    @(negedge HCLK);
    HRESETn = 1'b1;
    step();

    // Word write, bytes emitted LSB first
    set_wr(32'h44332211, 2'd2, 2'd0);
    byte_ready = 1'b1;
    step();
    buffer_write_en = 1'b0;
    wexp = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int k = 0; k < 4; k++) begin
      chk("word_byte", 32'(byte_out), 32'(wexp[k]));
      chk("word_last", 32'(byte_last), 32'(k == 3));
      chk("word_rwait", 32'(read_wait), 32'(1));
      step();
    end
    chk("word_empty_valid", 32'(byte_valid), 32'(0));
    chk("word_empty_rwait", 32'(read_wait), 32'(0));

    // Reversal: byte rev3, halfword rev2
    set_wr(32'h00000001, 2'd0, 2'd3);
    step();
    buffer_write_en = 1'b0;
    chk("rev_byte", 32'(byte_out), 32'h80);
    chk("rev_byte_last", 32'(byte_last), 32'(1));
    step();
    set_wr(32'hFFFF0001, 2'd1, 2'd2);
    step();
    buffer_write_en = 1'b0;
    chk("rev_hw_b0", 32'(byte_out), 32'h00);
    chk("rev_hw_b0_last", 32'(byte_last), 32'(0));
    step();
    chk("rev_hw_b1", 32'(byte_out), 32'h80);
    chk("rev_hw_b1_last", 32'(byte_last), 32'(1));
    step();

    // Back-pressure: third word held while full
    words = '{32'hA3A2A1A0, 32'hB3B2B1B0, 32'hC3C2C1C0};
    byte_ready = 1'b0;
    set_wr(words[0], 2'd2, 2'd0);
    step();
    set_wr(words[1], 2'd2, 2'd0);
    step();
    chk("bp_full", 32'(buffer_full), 32'(1));
    set_wr(words[2], 2'd2, 2'd0);
    repeat (3) step();
    chk("bp_still_full", 32'(buffer_full), 32'(1));
    byte_ready = 1'b1;
    c_at = -1;
    for (int k = 0; k < 40 && got.size() < 12; k++) begin
      if (byte_valid && byte_ready) got.push_back(byte_out);
      step();
      if (last_acc && c_at < 0) begin
        c_at = k;
        buffer_write_en = 1'b0;
      end
    end
    buffer_write_en = 1'b0;
    chk("bp_c_accept_cycle", 32'(c_at), 32'(4));
    chk("bp_byte_count", 32'(got.size()), 32'(12));
    for (int i = 0; i < got.size(); i++)
      chk("bp_order", 32'(got[i]), 32'(8'(words[i / 4] >> (8 * (i % 4)))));

    // Chain reset with two entries queued and engine busy
    byte_ready = 1'b0;
    set_wr(32'h12345678, 2'd2, 2'd1);
    step();
    set_wr(32'h9ABCDEF0, 2'd2, 2'd0);
    step();
    buffer_write_en = 1'b0;
    engine_busy = 1'b1;
    reset_chain = 1'b1;
    step();
    reset_chain = 1'b0;
    chk("cr_valid_drop", 32'(byte_valid), 32'(0));
    chk("cr_pending", 32'(reset_pending), 32'(1));
    chk("cr_full_clear", 32'(buffer_full), 32'(0));
    set_wr(32'h0000AA55, 2'd1, 2'd0);
    step();
    step();
    chk("cr_req_wait_busy", 32'(crc_rst_req), 32'(0));
    engine_busy = 1'b0;
    step();
    chk("cr_req_up", 32'(crc_rst_req), 32'(1));
    chk("cr_write_held", 32'(byte_valid), 32'(0));
    step();
    crc_rst_ack = 1'b1;
    step();
    crc_rst_ack = 1'b0;
    chk("cr_pending_fall", 32'(reset_pending), 32'(0));
    chk("cr_req_fall", 32'(crc_rst_req), 32'(0));
    step();
    buffer_write_en = 1'b0;
    chk("cr_write_after", 32'(byte_valid), 32'(1));
    chk("cr_write_byte", 32'(byte_out), 32'h55);
    byte_ready = 1'b1;
    repeat (3) step();

    // Same-cycle reset_chain and write
    set_wr(32'hDEADBEEF, 2'd2, 2'd0);
    reset_chain = 1'b1;
    step();
    reset_chain = 1'b0;
    buffer_write_en = 1'b0;
    step();
    crc_rst_ack = 1'b1;
    step();
    crc_rst_ack = 1'b0;
    chk("same_cycle_dropped", 32'(byte_valid), 32'(0));
    chk("same_cycle_full", 32'(buffer_full), 32'(0));
    step();

    // Random traffic with a host that holds stalled writes
    req_active = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (req_active && last_acc) req_active = 1'b0;
      if (!req_active && $urandom_range(0, 2) == 0) begin
        set_wr($urandom, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
        req_active = 1'b1;
      end
      buffer_write_en = req_active;
      byte_ready  = ($urandom_range(0, 3) != 0);
      engine_busy = ($urandom_range(0, 3) == 0);
      reset_chain = ($urandom_range(0, 39) == 0);
      crc_rst_ack = ($urandom_range(0, 2) == 0);
      step();
    end
    buffer_write_en = 1'b0;
    reset_chain = 1'b0;
    engine_busy = 1'b0;
    crc_rst_ack = 1'b1;
    byte_ready = 1'b1;
    repeat (12) step();
    crc_rst_ack = 1'b0;

    // Asynchronous reset mid-transfer
    byte_ready = 1'b0;
    set_wr(32'h87654321, 2'd2, 2'd0);
    step();
    set_wr(32'h0F0E0D0C, 2'd2, 2'd0);
    step();
    buffer_write_en = 1'b0;
    chk("ar_pre_full", 32'(buffer_full), 32'(1));
    #2;
    HRESETn = 1'b0;
    #1;
    chk_all_zero("async_rst");
    model_reset();
    @(negedge HCLK);
    HRESETn = 1'b1;
    step();
    chk("ar_post_valid", 32'(byte_valid), 32'(0));
    chk("ar_post_full", 32'(buffer_full), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
